// File: rtl/codec_cfg_pkg.sv
// Shared types and the codec register table for the configuration sequencer.
// Table entries are {reg[6:0], value[8:0]}, issued in index order.
package codec_cfg_pkg;

   localparam int NUM_CFG_WORDS = 7;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEND  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_GAP   = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERROR = 3'd5
   } cfg_state_e;

   localparam logic [15:0] CFG_WORDS [NUM_CFG_WORDS] = '{
      16'h1E00,   // reset
      16'h1201,   // activate
      16'h100C,   // 8 kHz sample rate
      16'h0E42,   // master mode, 16-bit
      16'h0C00,   // power on
      16'h0A01,   // DAC path
      16'h0815    // mic enable
   };

   // Out-of-range index (step 7 after completion) holds the last word.
   function automatic logic [15:0] cfg_word(input logic [2:0] idx);
      logic [15:0] w;
      case (idx)
         3'd0:    w = CFG_WORDS[0];
         3'd1:    w = CFG_WORDS[1];
         3'd2:    w = CFG_WORDS[2];
         3'd3:    w = CFG_WORDS[3];
         3'd4:    w = CFG_WORDS[4];
         3'd5:    w = CFG_WORDS[5];
         default: w = CFG_WORDS[6];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/cfg_timer.sv
// Loadable saturating down-counter; expire is high in the last counted cycle,
// so a load of N yields exactly N cycles in the consuming state.
module cfg_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Codec configuration sequencer: writes the package table through an I2C master.
// Optional feature macro CODEC_CFG_RETRY_EN re-sends a failed word up to MAX_RETRY times.
module codec_cfg_sequencer
   import codec_cfg_pkg::*;
#(
   parameter logic [6:0] I2C_ADDR       = 7'h1A,
   parameter int         GAP_CYCLES     = 1000,
   parameter int         TIMEOUT_CYCLES = 100000,
   parameter int         MAX_RETRY      = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_cfg,
   output logic        i2c_start,
   output logic        i2c_rw,
   output logic [6:0]  i2c_addr,
   output logic [15:0] i2c_data,
   input  logic        i2c_done,
   input  logic        i2c_ack,
   output logic        cfg_busy,
   output logic        cfg_done,
   output logic        cfg_error,
   output logic [2:0]  cfg_step,
   output cfg_state_e  dbg_state
);

   localparam int TMR_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [2:0] LAST_STEP = 3'(NUM_CFG_WORDS - 1);
   localparam logic [2:0] DONE_STEP = 3'd7;

   cfg_state_e       state_q, state_d;
   logic [2:0]       step_q, step_d;
   logic [15:0]      data_q, data_d;
   logic             tmr_load;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_expire;
   logic             fail;
`ifdef CODEC_CFG_RETRY_EN
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RTY_W-1:0] retry_cnt_q, retry_cnt_d;
   logic             gap_retry_q, gap_retry_d;
`endif

   cfg_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expire   (tmr_expire)
   );

   // Handshake: i2c_start is a one-cycle launch; the master answers with a one-cycle
   // i2c_done whose i2c_ack is sampled only in WAIT. i2c_data holds from SEND until WAIT exits.
   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      data_d   = data_q;
      tmr_load = 1'b0;
      tmr_val  = TMR_W'(GAP_CYCLES);
      fail     = 1'b0;
`ifdef CODEC_CFG_RETRY_EN
      retry_cnt_d = retry_cnt_q;
      gap_retry_d = gap_retry_q;
`endif
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start_cfg) begin
               state_d = ST_SEND;
               step_d  = '0;
               data_d  = cfg_word(3'd0);
`ifdef CODEC_CFG_RETRY_EN
               retry_cnt_d = '0;
               gap_retry_d = 1'b0;
`endif
            end
         end
         ST_SEND: begin
            state_d  = ST_WAIT;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(TIMEOUT_CYCLES);
         end
         ST_WAIT: begin
            if (i2c_done && i2c_ack) begin
               state_d  = ST_GAP;
               tmr_load = 1'b1;
`ifdef CODEC_CFG_RETRY_EN
               retry_cnt_d = '0;
               gap_retry_d = 1'b0;
`endif
            end else if (i2c_done || tmr_expire) begin
               fail = 1'b1;
            end
            if (fail) begin
`ifdef CODEC_CFG_RETRY_EN
               if (retry_cnt_q < RTY_W'(MAX_RETRY)) begin
                  retry_cnt_d = retry_cnt_q + 1'b1;
                  gap_retry_d = 1'b1;
                  state_d     = ST_GAP;
                  tmr_load    = 1'b1;
               end else begin
                  state_d = ST_ERROR;
               end
`else
               state_d = ST_ERROR;
`endif
            end
         end
         ST_GAP: begin
            if (tmr_expire) begin
`ifdef CODEC_CFG_RETRY_EN
               if (gap_retry_q) begin
                  state_d = ST_SEND;
               end else
`endif
               if (step_q == LAST_STEP) begin
                  state_d = ST_DONE;
                  step_d  = DONE_STEP;
               end else begin
                  state_d = ST_SEND;
                  step_d  = step_q + 3'd1;
                  data_d  = cfg_word(step_q + 3'd1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         data_q  <= cfg_word(3'd0);
`ifdef CODEC_CFG_RETRY_EN
         retry_cnt_q <= '0;
         gap_retry_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         data_q  <= data_d;
`ifdef CODEC_CFG_RETRY_EN
         retry_cnt_q <= retry_cnt_d;
         gap_retry_q <= gap_retry_d;
`endif
      end
   end

   always_comb begin
      i2c_start = (state_q == ST_SEND);
      cfg_busy  = (state_q == ST_SEND) || (state_q == ST_WAIT) || (state_q == ST_GAP);
      cfg_done  = (state_q == ST_DONE);
      cfg_error = (state_q == ST_ERROR);
   end

   assign i2c_rw    = 1'b0;
   assign i2c_addr  = I2C_ADDR;
   assign i2c_data  = data_q;
   assign cfg_step  = step_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Randomized bench for codec_cfg_sequencer: a response plan per transfer drives an I2C
// slave model; a table-walking reference model predicts words, timing and final status.
module tb_codec_cfg_sequencer;

   localparam int GAP  = 4;
   localparam int TMO  = 50;
   localparam int MAXR = 3;
`ifdef CODEC_CFG_RETRY_EN
   localparam bit RETRY_ON = 1'b1;
`else
   localparam bit RETRY_ON = 1'b0;
`endif
   localparam logic [15:0] WORD_TBL [7] = '{16'h1E00, 16'h1201, 16'h100C, 16'h0E42,
                                            16'h0C00, 16'h0A01, 16'h0815};

   typedef enum int {R_ACK, R_NACK, R_NONE} resp_e;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_cfg = 1'b0;
   logic        i2c_done = 1'b0;
   logic        i2c_ack = 1'b0;
   logic        i2c_start, i2c_rw, cfg_busy, cfg_done, cfg_error;
   logic [6:0]  i2c_addr;
   logic [15:0] i2c_data;
   logic [2:0]  cfg_step;
   logic [2:0]  dbg_state;

   always #5 clk = ~clk;

   codec_cfg_sequencer #(
      .I2C_ADDR       (7'h1A),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TMO),
      .MAX_RETRY      (MAXR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start_cfg (start_cfg),
      .i2c_start (i2c_start),
      .i2c_rw    (i2c_rw),
      .i2c_addr  (i2c_addr),
      .i2c_data  (i2c_data),
      .i2c_done  (i2c_done),
      .i2c_ack   (i2c_ack),
      .cfg_busy  (cfg_busy),
      .cfg_done  (cfg_done),
      .cfg_error (cfg_error),
      .cfg_step  (cfg_step),
      .dbg_state (dbg_state)
   );

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [15:0] exp_q[$];
   logic [2:0]  exp_step_q[$];
   resp_e       plan_q[$];
   logic        exp_done, exp_err;
   logic [2:0]  exp_final_step;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   // Reference: walk the table word by word, consuming one plan entry per attempt.
   task automatic build_expect();
      int    p;
      int    tries;
      resp_e r;
      p = 0;
      exp_q.delete();
      exp_step_q.delete();
      exp_done = 1'b0;
      exp_err = 1'b0;
      exp_final_step = 3'd0;
      for (int w = 0; w < 7; w++) begin
         tries = 0;
         while (1) begin
            r = (p < plan_q.size()) ? plan_q[p] : R_ACK;
            p++;
            exp_q.push_back(WORD_TBL[w]);
            exp_step_q.push_back(3'(w));
            if (r == R_ACK) break;
            if (RETRY_ON && tries < MAXR) begin
               tries++;
            end else begin
               exp_err = 1'b1;
               exp_final_step = 3'(w);
               return;
            end
         end
      end
      exp_done = 1'b1;
      exp_final_step = 3'd7;
   endtask

   task automatic run_seq();
      int    exp_evt;
      int    fails;
      int    p;
      int    d;
      int    extra;
      int    strays;
      logic  ended;
      resp_e r;
      build_expect();
      p = 0;
      fails = 0;
      extra = 0;
      ended = 1'b0;
      start_cfg = 1'b1;
      tick();
      start_cfg = 1'b0;
      exp_evt = cyc;
      for (int g = 0; g < 3000 && !ended; g++) begin
         i2c_done = 1'b0;
         i2c_ack = 1'($urandom_range(0, 1));
         if ((i2c_start || cfg_done || cfg_error) && exp_evt >= 0) begin
            check_eq("evt_time", cyc, exp_evt);
            exp_evt = -1;
         end
         if (cfg_done || cfg_error) begin
            ended = 1'b1;
         end else if (i2c_start) begin
            if (exp_q.size() > 0) begin
               check_eq("word", i2c_data, exp_q.pop_front());
               check_eq("step", cfg_step, exp_step_q.pop_front());
               check_eq("addr_rw", {i2c_addr, i2c_rw}, {7'h1A, 1'b0});
            end else begin
               extra++;
            end
            r = (p < plan_q.size()) ? plan_q[p] : R_ACK;
            p++;
            if (r == R_NONE) begin
               if (RETRY_ON && fails < MAXR) begin
                  fails++;
                  exp_evt = cyc + TMO + 1 + GAP;
               end else begin
                  exp_evt = cyc + TMO + 1;
               end
            end else begin
               d = $urandom_range(1, 6);
               for (int k = 0; k < d; k++) begin
                  if (k == 1 && $urandom_range(0, 3) == 0) start_cfg = 1'b1;
                  tick();
                  start_cfg = 1'b0;
               end
               i2c_done = 1'b1;
               i2c_ack = (r == R_ACK);
               if (r == R_ACK) begin
                  fails = 0;
                  exp_evt = cyc + GAP + 1;
               end else if (RETRY_ON && fails < MAXR) begin
                  fails++;
                  exp_evt = cyc + GAP + 1;
               end else begin
                  exp_evt = cyc + 1;
               end
            end
         end
         if (!ended) tick();
      end
      i2c_done = 1'b0;
      check_eq("seq_end", ended, 1'b1);
      check_eq("done", cfg_done, exp_done);
      check_eq("error", cfg_error, exp_err);
      check_eq("final_step", cfg_step, exp_final_step);
      check_eq("busy_end", cfg_busy, 1'b0);
      check_eq("left_words", exp_q.size(), 0);
      check_eq("extra_launch", extra, 0);
      strays = 0;
      for (int k = 0; k < 12; k++) begin
         i2c_done = (k == 3);
         i2c_ack = 1'b1;
         tick();
         if (i2c_start) strays++;
      end
      i2c_done = 1'b0;
      check_eq("stray_start", strays, 0);
      check_eq("hold_flags", {cfg_done, cfg_error}, {exp_done, exp_err});
   endtask

   task automatic reset_abort();
      int launches;
      int idle_starts;
      launches = 0;
      start_cfg = 1'b1;
      tick();
      start_cfg = 1'b0;
      for (int g = 0; g < 500 && launches < 4; g++) begin
         i2c_done = 1'b0;
         if (i2c_start) begin
            launches++;
            if (launches < 4) begin
               tick();
               tick();
               i2c_done = 1'b1;
               i2c_ack = 1'b1;
            end
         end
         if (launches < 4) tick();
      end
      check_eq("abort_word", i2c_data, 16'h0E42);
      tick();
      tick();
      tick();
      #2 rst = 1'b0;
      #1;
      check_eq("rst_start", i2c_start, 1'b0);
      check_eq("rst_busy", cfg_busy, 1'b0);
      check_eq("rst_step", cfg_step, 3'd0);
      check_eq("rst_data", i2c_data, 16'h1E00);
      check_eq("rst_flags", {cfg_done, cfg_error}, 2'b00);
      tick();
      tick();
      rst = 1'b1;
      idle_starts = 0;
      for (int k = 0; k < 8; k++) begin
         i2c_done = (k == 1);
         i2c_ack = 1'b1;
         tick();
         if (i2c_start || cfg_busy) idle_starts++;
      end
      i2c_done = 1'b0;
      check_eq("no_resume", idle_starts, 0);
      plan_q.delete();
      run_seq();
   endtask

   initial begin
      int x;
      rst = 1'b0;
      tick();
      tick();
      check_eq("reset_start", i2c_start, 1'b0);
      check_eq("reset_busy", cfg_busy, 1'b0);
      check_eq("reset_flags", {cfg_done, cfg_error}, 2'b00);
      check_eq("reset_step", cfg_step, 3'd0);
      check_eq("reset_data", i2c_data, 16'h1E00);
      check_eq("reset_addr_rw", {i2c_addr, i2c_rw}, {7'h1A, 1'b0});
      rst = 1'b1;
      tick();
      tick();
      check_eq("idle_busy", cfg_busy, 1'b0);

      plan_q.delete();
      run_seq();
      run_seq();
      plan_q = '{R_ACK, R_ACK, R_NACK, R_NACK, R_ACK};
      run_seq();
      plan_q = '{R_ACK, R_ACK, R_ACK, R_ACK, R_NACK, R_NACK, R_NACK, R_NACK, R_NACK};
      run_seq();
      plan_q = '{R_NONE, R_NONE, R_NONE, R_NONE};
      run_seq();
      reset_abort();

      for (int t = 0; t < 8; t++) begin
         plan_q.delete();
         for (int i = 0; i < 14; i++) begin
            x = $urandom_range(0, 99);
            plan_q.push_back((x < 80) ? R_ACK : (x < 95) ? R_NACK : R_NONE);
         end
         run_seq();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
